// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divide and phase
// strobes derived from one fabric clock, with lock and common alignment indicators.
module clk_enable_gen #(
  parameter int NUM_CLKS   = 4,
  parameter int DIV_WIDTH  = 8,
  parameter logic [NUM_CLKS*DIV_WIDTH-1:0] DIV_DEFAULT = {NUM_CLKS{DIV_WIDTH'(25)}},
  parameter int LOCK_DELAY = 16
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic [NUM_CLKS*DIV_WIDTH-1:0] div_i,
  input  logic [NUM_CLKS*DIV_WIDTH-1:0] phase_i,
  input  logic                          cfg_load,
  input  logic                          sync_i,
  output logic [NUM_CLKS-1:0]           ce_o,
  output logic                          align_o,
  output logic                          locked
);

  localparam int LW = $clog2(LOCK_DELAY + 1);

  typedef logic [DIV_WIDTH-1:0] field_t;

  field_t        div_q   [NUM_CLKS];
  field_t        phase_q [NUM_CLKS];
  field_t        cnt_q   [NUM_CLKS];
  field_t        n_eff   [NUM_CLKS];
  field_t        p_eff   [NUM_CLKS];
  logic [LW-1:0] lock_cnt;
  logic          sync_q1;
  logic          sync_q2;
  logic          sync_rise;
  logic          all_zero;

  // A divide of zero behaves as one; the phase is clamped into the counter range.
  always_comb begin
    for (int k = 0; k < NUM_CLKS; k++) begin
      n_eff[k] = (div_q[k] == '0) ? field_t'(1) : div_q[k];
      p_eff[k] = (phase_q[k] > (n_eff[k] - field_t'(1))) ? (n_eff[k] - field_t'(1))
                                                         : phase_q[k];
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLKS; k++) begin
        div_q[k]   <= DIV_DEFAULT[k*DIV_WIDTH +: DIV_WIDTH];
        phase_q[k] <= '0;
      end
    end else if (cfg_load) begin
      for (int k = 0; k < NUM_CLKS; k++) begin
        div_q[k]   <= div_i[k*DIV_WIDTH +: DIV_WIDTH];
        phase_q[k] <= phase_i[k*DIV_WIDTH +: DIV_WIDTH];
      end
    end
  end

  // Two-stage detect: the extra stage delays the restart by one edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sync_i;
      sync_q2 <= sync_q1;
    end
  end

  assign sync_rise = sync_q1 & ~sync_q2;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLKS; k++) cnt_q[k] <= '0;
    end else if (cfg_load || sync_rise) begin
      for (int k = 0; k < NUM_CLKS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CLKS; k++) begin
        cnt_q[k] <= (cnt_q[k] == (n_eff[k] - field_t'(1))) ? '0 : cnt_q[k] + field_t'(1);
      end
    end
  end

  // Lock counter saturates at LOCK_DELAY; locked tracks the counter's next value.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (cfg_load) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (lock_cnt != LW'(LOCK_DELAY)) begin
      lock_cnt <= lock_cnt + LW'(1);
      locked   <= ((lock_cnt + LW'(1)) == LW'(LOCK_DELAY));
    end else begin
      locked   <= 1'b1;
    end
  end

  always_comb begin
    ce_o     = '0;
    all_zero = 1'b1;
    for (int k = 0; k < NUM_CLKS; k++) begin
      ce_o[k] = locked && (cnt_q[k] == p_eff[k]);
      if (cnt_q[k] != '0) all_zero = 1'b0;
    end
    align_o = locked && all_zero;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomised scoreboard bench for clk_enable_gen: a cycle-level reference model
// predicts each cycle's outputs, a separate monitor compares them to the DUT.
module tb_clk_enable_gen;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int LD = 16;

  logic             refclk = 1'b0;
  logic             rst;
  logic [NC*DW-1:0] div_i;
  logic [NC*DW-1:0] phase_i;
  logic             cfg_load;
  logic             sync_i;
  logic [NC-1:0]    ce_o;
  logic             align_o;
  logic             locked;

  clk_enable_gen #(
    .NUM_CLKS(NC), .DIV_WIDTH(DW), .LOCK_DELAY(LD)
  ) dut (
    .refclk(refclk), .rst(rst), .div_i(div_i), .phase_i(phase_i),
    .cfg_load(cfg_load), .sync_i(sync_i), .ce_o(ce_o), .align_o(align_o), .locked(locked)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NC+1:0] exp_q[$];

  // Model state: edges since the last counter restart, edges since last lock loss.
  int   t_m, lock_age, n, p, c;
  int   div_m [NC];
  int   phase_m [NC];
  logic s1, s2, rise, lk, all0;
  logic [NC-1:0] ce_m;

  task automatic check_output(input string name, input logic [NC+1:0] act, input logic [NC+1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got ce/align/locked=%b expected %b", name, $time, act, exp);
    end
  endtask

  always @(posedge refclk) begin
    if (rst) begin
      t_m = 0; lock_age = 0; s1 = 1'b0; s2 = 1'b0;
      for (int k = 0; k < NC; k++) begin
        div_m[k] = 25; phase_m[k] = 0;
      end
      exp_q.push_back('0);
    end else begin
      rise = s1 && !s2;
      s2 = s1;
      s1 = sync_i;
      if (cfg_load) begin
        for (int k = 0; k < NC; k++) begin
          div_m[k]   = int'(div_i[k*DW +: DW]);
          phase_m[k] = int'(phase_i[k*DW +: DW]);
        end
        t_m = 0; lock_age = 0;
      end else begin
        t_m = rise ? 0 : t_m + 1;
        if (lock_age < LD) lock_age++;
      end
      lk = (lock_age >= LD);
      all0 = 1'b1;
      ce_m = '0;
      for (int k = 0; k < NC; k++) begin
        n = (div_m[k] == 0) ? 1 : div_m[k];
        p = (phase_m[k] < n) ? phase_m[k] : n - 1;
        c = t_m % n;
        if (c != 0) all0 = 1'b0;
        ce_m[k] = lk && (c == p);
      end
      exp_q.push_back({ce_m, lk && all0, lk});
    end
  end

  always begin
    @(posedge refclk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL scoreboard_empty at %0t: got no entry expected one", $time);
    end else begin
      check_output("cycle", {ce_o, align_o, locked}, exp_q.pop_front());
    end
  end

  task automatic apply_stimulus(input logic [NC*DW-1:0] d, input logic [NC*DW-1:0] ph,
                                input logic ld, input logic sy, input int cycles);
    div_i = d; phase_i = ph; cfg_load = ld; sync_i = sy;
    repeat (cycles) @(negedge refclk);
  endtask

  logic [NC*DW-1:0] rnd_d, rnd_p;
  int r;

  initial begin
    rst = 1'b1; cfg_load = 1'b0; sync_i = 1'b0; div_i = '0; phase_i = '0;
    #2;
    check_output("reset_state", {ce_o, align_o, locked}, '0);
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    apply_stimulus('0, '0, 1'b0, 1'b0, 80);

    // ch0 25/0, ch1 10/3, ch2 div0 ph5, ch3 div4 ph9 (clamped)
    apply_stimulus({8'd4, 8'd0, 8'd10, 8'd25}, {8'd9, 8'd5, 8'd3, 8'd0}, 1'b1, 1'b0, 1);
    apply_stimulus({8'd4, 8'd0, 8'd10, 8'd25}, {8'd9, 8'd5, 8'd3, 8'd0}, 1'b0, 1'b0, 120);
    apply_stimulus({8'd4, 8'd1, 8'd10, 8'd25}, {8'd9, 8'd5, 8'd3, 8'd0}, 1'b1, 1'b0, 1);
    apply_stimulus({8'd4, 8'd1, 8'd10, 8'd25}, {8'd9, 8'd5, 8'd3, 8'd0}, 1'b0, 1'b0, 37);

    // sync held high for 40 cycles mid-period
    apply_stimulus({8'd4, 8'd1, 8'd10, 8'd25}, {8'd9, 8'd5, 8'd3, 8'd0}, 1'b0, 1'b1, 40);
    apply_stimulus({8'd4, 8'd1, 8'd10, 8'd25}, {8'd9, 8'd5, 8'd3, 8'd0}, 1'b0, 1'b0, 30);

    // sync edge lands on the same edge as cfg_load
    apply_stimulus({8'd4, 8'd1, 8'd10, 8'd25}, {8'd9, 8'd5, 8'd3, 8'd0}, 1'b0, 1'b1, 1);
    apply_stimulus({8'd6, 8'd3, 8'd7, 8'd12}, {8'd2, 8'd1, 8'd6, 8'd11}, 1'b1, 1'b1, 1);
    apply_stimulus({8'd6, 8'd3, 8'd7, 8'd12}, {8'd2, 8'd1, 8'd6, 8'd11}, 1'b0, 1'b0, 60);

    // div/phase inputs wiggle with no cfg_load
    for (int i = 0; i < 60; i++)
      apply_stimulus($urandom, $urandom, 1'b0, 1'b0, 1);

    // cfg_load held for several edges keeps lock down
    apply_stimulus({8'd2, 8'd5, 8'd3, 8'd8}, {8'd1, 8'd4, 8'd0, 8'd7}, 1'b1, 1'b0, 5);
    apply_stimulus({8'd2, 8'd5, 8'd3, 8'd8}, {8'd1, 8'd4, 8'd0, 8'd7}, 1'b0, 1'b0, 40);

    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      for (int k = 0; k < NC; k++) begin
        rnd_d[k*DW +: DW] = DW'($urandom_range(0, 12));
        rnd_p[k*DW +: DW] = DW'($urandom_range(0, 15));
      end
      if (r < 2)       apply_stimulus(rnd_d, rnd_p, 1'b1, sync_i, 1);
      else if (r < 7)  apply_stimulus(div_i, phase_i, 1'b0, ~sync_i, 1);
      else if (r < 12) apply_stimulus(rnd_d, rnd_p, 1'b0, sync_i, 1);
      else             apply_stimulus(div_i, phase_i, 1'b0, sync_i, 1);
    end

    // asynchronous reset between edges while locked
    apply_stimulus({8'd3, 8'd1, 8'd2, 8'd4}, '0, 1'b1, 1'b0, 1);
    apply_stimulus({8'd3, 8'd1, 8'd2, 8'd4}, '0, 1'b0, 1'b0, 30);
    #2 rst = 1'b1;
    #1 check_output("async_reset", {ce_o, align_o, locked}, '0);
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    apply_stimulus('0, '0, 1'b0, 1'b0, 80);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
